mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   Byte-serial memory controller. Sits directly downstream of the MA (memory-access) stage and the IF fetch unit.
//   Arbitrates their 32-bit requests onto the single 8-bit RAM/IO bus, one byte per cycle, little-endian.
//   Returns assembled read data, and signals completion by dropping the requester's busy line.
// PARAMETERS
//   ADDR_W   32  width of mem_a and of request addresses
// PORTS
//   clk        in   1       clock
//   rst        in   1       synchronous reset, active-high
//   rdy        in   1       global enable; 0 = every register holds
//   ma_re      in   1       MA read request (level, held until busy falls)
//   ma_we      in   1       MA write request; wins over ma_re if both are high
//   ma_addr    in   ADDR_W  MA byte address
//   ma_width   in   3       000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
//   ma_wdata   in   32      store data, low bytes used
//   ma_rdata   out  32      load data, zero-filled above width
//   ma_busy    out  1       MA request accepted and in progress
//   if_re      in   1       fetch request (word read only)
//   if_addr    in   ADDR_W  fetch address
//   if_rdata   out  32      fetched instruction
//   if_busy    out  1       fetch accepted and in progress
//   mem_din    in   8       RAM read byte, valid the cycle after its address cycle
//   mem_dout   out  8       RAM write byte
//   mem_a      out  ADDR_W  RAM byte address
//   mem_wr     out  1       1 = write, 0 = read
// BEHAVIOUR
//   Reset: all outputs 0 (mem_a, mem_dout, mem_wr, ma_busy, if_busy, ma_rdata, if_rdata); state IDLE; counters 0.
//     Reset aborts any access in progress, and the aborted access produces no further RAM cycles.
//   rdy=0: state, counters, and all outputs hold their values.
//   Byte count N: width[1] ? 4 : width[0] ? 2 : 1. Codes 011 and 11x are treated as word. Fetch: N=4.
//   FSM: IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE:
//     - If (ma_re|ma_we), accept MA. Else if if_re, accept IF. MA has fixed priority.
//     - Accept edge: latch port, addr, N, we, wdata; requester busy <= 1; cnt <= 0.
//     - Same edge: mem_a <= addr; mem_wr <= we; mem_dout <= wdata[7:0].
//   ACCESS, write:
//     - Each edge advances cnt. mem_a <= addr+cnt; mem_dout <= byte[cnt].
//     - Busy is high for exactly N cycles.
//     - The final edge sets mem_wr <= 0 and busy <= 0, then goes to DONE.
//   ACCESS, read:
//     - Byte k is captured from mem_din on the edge two after its address was issued.
//     - Next addresses are issued back-to-back.
//     - Busy is high for N+1 cycles.
//     - The final edge writes the assembled word into the requester's rdata in the same edge that busy falls.
//   rdata is stable from the busy-falling edge until that port's next completion.
//   mem_a is ADDR_W wide and arithmetic wraps modulo 2^ADDR_W; 0xFFFFFFFF + 1 -> 0x00000000.
//   DONE: lasts one cycle and ignores all requests, because the requester drops re/we on the edge it samples busy=0.
//     mem_wr stays 0; next state IDLE.
//   A request that rises during ACCESS or DONE on the other port waits. It is never lost, since requests are level-held.
//   Busy is never high on both ports at once.
// CONFIGURATION
//   MEMCTRL_ERR_EN defined:
//     - Adds output ma_err (1 bit, reset 0).
//     - A misaligned MA access (half with addr[0]=1, or word with addr[1:0]!=0) issues no RAM cycle.
//     - ma_busy is high for exactly one cycle; ma_rdata is unchanged.
//     - ma_err is high in the same cycle as busy and clears on the next accept.
//   MEMCTRL_ERR_EN undefined: no ma_err port; misaligned accesses proceed byte-serially like aligned ones.
// TESTING
//   1. SW 0x11223344 @0x100:
//      - 4 cycles with mem_wr=1 at a=0x100..0x103, dout=44,33,22,11.
//      - ma_busy is high for 4 cycles, then mem_wr=0.
//   2. LB @0x20, RAM byte 0x80:
//      - ma_busy is high for 2 cycles.
//      - ma_rdata=0x00000080 when busy falls (MA does the sign extension).
//   3. ma_re and if_re rise in the same cycle:
//      - The MA word completes first.
//      - if_busy rises only after DONE, and fetch data is correct.
//   4. rst pulsed during the 3rd byte of a write:
//      - The next edge gives mem_wr=0 and busy=0; no further bytes are written.
//      - A new LW afterwards returns the correct data.
//   5. rdy=0 for 3 cycles mid LW: outputs freeze; the completed word is identical to the rdy=1 run.
//   6. ERR_EN build, LW @0x102: no mem_wr and no address change; ma_err=1 and ma_busy=1 for one cycle.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bundle of MA request, IF fetch and byte-wide RAM bus signals around mem_access_ctrl.
// MEMCTRL_ERR_EN adds the ma_err misalignment flag.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              ma_re;
  logic              ma_we;
  logic [ADDR_W-1:0] ma_addr;
  logic [2:0]        ma_width;
  logic [31:0]       ma_wdata;
  logic [31:0]       ma_rdata;
  logic              ma_busy;
`ifdef MEMCTRL_ERR_EN
  logic              ma_err;
`endif

  logic              if_re;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_busy;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  // Master is the requester/RAM environment, slave is the controller.
  modport master (
    output ma_re, ma_we, ma_addr, ma_width, ma_wdata,
    input  ma_rdata, ma_busy,
    output if_re, if_addr,
    input  if_rdata, if_busy,
    output mem_din,
    input  mem_dout, mem_a, mem_wr
`ifdef MEMCTRL_ERR_EN
    , input ma_err
`endif
  );

  modport slave (
    input  ma_re, ma_we, ma_addr, ma_width, ma_wdata,
    output ma_rdata, ma_busy,
    input  if_re, if_addr,
    output if_rdata, if_busy,
    input  mem_din,
    output mem_dout, mem_a, mem_wr
`ifdef MEMCTRL_ERR_EN
    , output ma_err
`endif
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// Byte-serial little-endian memory controller arbitrating MA and IF requests onto an 8-bit RAM bus.
// Define MEMCTRL_ERR_EN to reject misaligned MA accesses with ma_err instead of running them.
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t            state, state_n;
  logic              sel_ma, sel_ma_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [2:0]        nbytes, nbytes_n;
  logic              we, we_n;
  logic [31:0]       wdata, wdata_n;
  logic [2:0]        cnt, cnt_n;
  logic [31:0]       asm_word, asm_word_n;

  logic [ADDR_W-1:0] mem_a, mem_a_n;
  logic [7:0]        mem_dout, mem_dout_n;
  logic              mem_wr, mem_wr_n;
  logic              ma_busy, ma_busy_n;
  logic              if_busy, if_busy_n;
  logic [31:0]       ma_rdata, ma_rdata_n;
  logic [31:0]       if_rdata, if_rdata_n;
`ifdef MEMCTRL_ERR_EN
  logic              ma_err, ma_err_n;
  logic              misaligned;
`endif

  logic [2:0]        ma_nbytes;
  logic [2:0]        cnt_inc;
  logic [1:0]        wr_idx;
  logic [1:0]        rd_idx;
  logic [ADDR_W-1:0] addr_step;
  logic [31:0]       asm_capt;

  assign ma_nbytes = bus.ma_width[1] ? 3'd4 : (bus.ma_width[0] ? 3'd2 : 3'd1);
  assign cnt_inc   = cnt + 3'd1;
  assign wr_idx    = cnt[1:0] + 2'd1;
  assign rd_idx    = cnt[1:0] - 2'd1;
  assign addr_step = addr + ADDR_W'(cnt_inc);

`ifdef MEMCTRL_ERR_EN
  assign misaligned = ((ma_nbytes == 3'd2) && bus.ma_addr[0]) ||
                      ((ma_nbytes == 3'd4) && (bus.ma_addr[1:0] != 2'b00));
`endif

  // Byte captured on a read edge belongs to the address issued two edges earlier.
  always_comb begin
    asm_capt = asm_word;
    asm_capt[8*rd_idx +: 8] = bus.mem_din;
  end

  always_comb begin
    state_n    = state;
    sel_ma_n   = sel_ma;
    addr_n     = addr;
    nbytes_n   = nbytes;
    we_n       = we;
    wdata_n    = wdata;
    cnt_n      = cnt;
    asm_word_n = asm_word;
    mem_a_n    = mem_a;
    mem_dout_n = mem_dout;
    mem_wr_n   = mem_wr;
    ma_busy_n  = ma_busy;
    if_busy_n  = if_busy;
    ma_rdata_n = ma_rdata;
    if_rdata_n = if_rdata;
`ifdef MEMCTRL_ERR_EN
    ma_err_n   = ma_err;
`endif

    case (state)
      IDLE: begin
        if (bus.ma_re || bus.ma_we) begin
          sel_ma_n   = 1'b1;
          addr_n     = bus.ma_addr;
          nbytes_n   = ma_nbytes;
          we_n       = bus.ma_we;
          wdata_n    = bus.ma_wdata;
          cnt_n      = 3'd0;
          asm_word_n = 32'd0;
          ma_busy_n  = 1'b1;
`ifdef MEMCTRL_ERR_EN
          ma_err_n   = 1'b0;
          if (misaligned) begin
            ma_err_n = 1'b1;
            state_n  = ERR;
          end else begin
            mem_a_n    = bus.ma_addr;
            mem_wr_n   = bus.ma_we;
            mem_dout_n = bus.ma_wdata[7:0];
            state_n    = ACCESS;
          end
`else
          mem_a_n    = bus.ma_addr;
          mem_wr_n   = bus.ma_we;
          mem_dout_n = bus.ma_wdata[7:0];
          state_n    = ACCESS;
`endif
        end else if (bus.if_re) begin
          sel_ma_n   = 1'b0;
          addr_n     = bus.if_addr;
          nbytes_n   = 3'd4;
          we_n       = 1'b0;
          cnt_n      = 3'd0;
          asm_word_n = 32'd0;
          if_busy_n  = 1'b1;
          mem_a_n    = bus.if_addr;
          mem_wr_n   = 1'b0;
`ifdef MEMCTRL_ERR_EN
          ma_err_n   = 1'b0;
`endif
          state_n    = ACCESS;
        end
      end

      ACCESS: begin
        if (we) begin
          if (cnt_inc == nbytes) begin
            mem_wr_n  = 1'b0;
            ma_busy_n = 1'b0;
            state_n   = DONE;
          end else begin
            cnt_n      = cnt_inc;
            mem_a_n    = addr_step;
            mem_dout_n = wdata[8*wr_idx +: 8];
          end
        end else begin
          if (cnt != 3'd0) asm_word_n = asm_capt;
          if (cnt == nbytes) begin
            if (sel_ma) begin
              ma_rdata_n = asm_capt;
              ma_busy_n  = 1'b0;
            end else begin
              if_rdata_n = asm_capt;
              if_busy_n  = 1'b0;
            end
            state_n = DONE;
          end else begin
            cnt_n = cnt_inc;
            // Addresses run ahead of captures; stop issuing once the last byte is out.
            if (cnt_inc < nbytes) mem_a_n = addr_step;
          end
        end
      end

      DONE: begin
        mem_wr_n = 1'b0;
        state_n  = IDLE;
      end

      ERR: begin
        ma_busy_n = 1'b0;
        state_n   = DONE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_ma   <= 1'b0;
      addr     <= '0;
      nbytes   <= 3'd0;
      we       <= 1'b0;
      wdata    <= 32'd0;
      cnt      <= 3'd0;
      asm_word <= 32'd0;
      mem_a    <= '0;
      mem_dout <= 8'd0;
      mem_wr   <= 1'b0;
      ma_busy  <= 1'b0;
      if_busy  <= 1'b0;
      ma_rdata <= 32'd0;
      if_rdata <= 32'd0;
`ifdef MEMCTRL_ERR_EN
      ma_err   <= 1'b0;
`endif
    end else if (rdy) begin
      state    <= state_n;
      sel_ma   <= sel_ma_n;
      addr     <= addr_n;
      nbytes   <= nbytes_n;
      we       <= we_n;
      wdata    <= wdata_n;
      cnt      <= cnt_n;
      asm_word <= asm_word_n;
      mem_a    <= mem_a_n;
      mem_dout <= mem_dout_n;
      mem_wr   <= mem_wr_n;
      ma_busy  <= ma_busy_n;
      if_busy  <= if_busy_n;
      ma_rdata <= ma_rdata_n;
      if_rdata <= if_rdata_n;
`ifdef MEMCTRL_ERR_EN
      ma_err   <= ma_err_n;
`endif
    end
  end

  assign bus.mem_a    = mem_a;
  assign bus.mem_dout = mem_dout;
  assign bus.mem_wr   = mem_wr;
  assign bus.ma_busy  = ma_busy;
  assign bus.if_busy  = if_busy;
  assign bus.ma_rdata = ma_rdata;
  assign bus.if_rdata = if_rdata;
`ifdef MEMCTRL_ERR_EN
  assign bus.ma_err   = ma_err;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a byte RAM model gated by rdy.
// Define MEMCTRL_ERR_EN to also exercise the misaligned-access rejection.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] ram [0:4095];
  logic [7:0] sw_bytes [4] = '{8'h44, 8'h33, 8'h22, 8'h11};

  mem_access_ctrl_if #(.ADDR_W(32)) bus ();

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after its address cycle.
  always @(posedge clk) begin
    if (rdy) begin
      if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
      bus.mem_din <= ram[bus.mem_a[11:0]];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One MA transaction; counts busy cycles and releases the request once busy falls.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [2:0] width,
                               input logic [31:0] wdata, output int busy_cycles);
    int finished;
    busy_cycles  = 0;
    finished     = 0;
    bus.ma_re    = !wr;
    bus.ma_we    = wr;
    bus.ma_addr  = addr;
    bus.ma_width = width;
    bus.ma_wdata = wdata;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ma_busy) busy_cycles++;
      else if (busy_cycles > 0) begin
        finished = 1;
        break;
      end
    end
    bus.ma_re = 1'b0;
    bus.ma_we = 1'b0;
    checkOutput("ma_complete", finished, 1);
  endtask

  initial begin
    int bc;
    int ma_fall, if_rise, if_fall, overlap, seen_ma, frz, writes;

    rst          = 1'b1;
    rdy          = 1'b1;
    bus.ma_re    = 1'b0;
    bus.ma_we    = 1'b0;
    bus.ma_addr  = 32'd0;
    bus.ma_width = 3'd0;
    bus.ma_wdata = 32'd0;
    bus.if_re    = 1'b0;
    bus.if_addr  = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_a", bus.mem_a, 32'd0);
    checkOutput("rst_mem_dout", bus.mem_dout, 32'd0);
    checkOutput("rst_mem_wr", bus.mem_wr, 32'd0);
    checkOutput("rst_ma_busy", bus.ma_busy, 32'd0);
    checkOutput("rst_if_busy", bus.if_busy, 32'd0);
    checkOutput("rst_ma_rdata", bus.ma_rdata, 32'd0);
    checkOutput("rst_if_rdata", bus.if_rdata, 32'd0);
    rst = 1'b0;

    // SW 0x11223344 @0x100, cycle by cycle
    repeat (2) @(negedge clk);
    bus.ma_we = 1'b1; bus.ma_addr = 32'h100; bus.ma_width = 3'b010; bus.ma_wdata = 32'h11223344;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("sw_wr", bus.mem_wr, 1);
      checkOutput("sw_a", bus.mem_a, 32'h100 + i);
      checkOutput("sw_dout", bus.mem_dout, sw_bytes[i]);
      checkOutput("sw_busy", bus.ma_busy, 1);
    end
    @(negedge clk);
    bus.ma_we = 1'b0;
    checkOutput("sw_busy_end", bus.ma_busy, 0);
    checkOutput("sw_wr_end", bus.mem_wr, 0);

    // Preload through the controller
    applyStimulus(1'b1, 32'h20, 3'b000, 32'h00000080, bc);
    checkOutput("sb_busy", bc, 1);
    applyStimulus(1'b1, 32'h21, 3'b000, 32'h000000AB, bc);
    applyStimulus(1'b1, 32'h40, 3'b001, 32'h00001234, bc);
    checkOutput("sh_busy", bc, 2);
    applyStimulus(1'b1, 32'h200, 3'b010, 32'hDEADBEEF, bc);
    applyStimulus(1'b1, 32'h300, 3'b010, 32'h00000000, bc);

    // Loads of each width, zero-filled
    applyStimulus(1'b0, 32'h20, 3'b000, 32'd0, bc);
    checkOutput("lb_busy", bc, 2);
    checkOutput("lb_data", bus.ma_rdata, 32'h00000080);
    applyStimulus(1'b0, 32'h40, 3'b101, 32'd0, bc);
    checkOutput("lhu_busy", bc, 3);
    checkOutput("lhu_data", bus.ma_rdata, 32'h00001234);
    applyStimulus(1'b0, 32'h100, 3'b011, 32'd0, bc);
    checkOutput("lw011_busy", bc, 5);
    checkOutput("lw011_data", bus.ma_rdata, 32'h11223344);
    repeat (3) @(negedge clk);
    checkOutput("rdata_stable", bus.ma_rdata, 32'h11223344);

    // Simultaneous MA and IF requests
    bus.ma_re = 1'b1; bus.ma_addr = 32'h100; bus.ma_width = 3'b010;
    bus.if_re = 1'b1; bus.if_addr = 32'h200;
    ma_fall = -1; if_rise = -1; if_fall = -1; overlap = 0; seen_ma = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.ma_busy && bus.if_busy) overlap++;
      if (bus.ma_busy) seen_ma = 1;
      else if (seen_ma != 0 && ma_fall < 0) begin
        ma_fall   = c;
        bus.ma_re = 1'b0;
      end
      if (bus.if_busy && if_rise < 0) if_rise = c;
      if (!bus.if_busy && if_rise >= 0 && if_fall < 0) begin
        if_fall   = c;
        bus.if_re = 1'b0;
      end
      if (if_fall >= 0) break;
    end
    bus.ma_re = 1'b0;
    bus.if_re = 1'b0;
    checkOutput("arb_ma_fall", ma_fall, 6);
    checkOutput("arb_if_rise", if_rise, 8);
    checkOutput("arb_if_fall", if_fall, 13);
    checkOutput("arb_overlap", overlap, 0);
    checkOutput("arb_ma_data", bus.ma_rdata, 32'h11223344);
    checkOutput("arb_if_data", bus.if_rdata, 32'hDEADBEEF);

    // Reset during the third byte of a write
    repeat (2) @(negedge clk);
    bus.ma_we = 1'b1; bus.ma_addr = 32'h300; bus.ma_width = 3'b010; bus.ma_wdata = 32'hDDCCBBAA;
    repeat (3) @(negedge clk);
    checkOutput("rst_wr_a", bus.mem_a, 32'h302);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.ma_we = 1'b0;
    checkOutput("rst_wr_mem_wr", bus.mem_wr, 0);
    checkOutput("rst_wr_busy", bus.ma_busy, 0);
    writes = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.mem_wr) writes++;
    end
    checkOutput("rst_wr_quiet", writes, 0);
    applyStimulus(1'b0, 32'h300, 3'b010, 32'd0, bc);
    checkOutput("rst_lw_busy", bc, 5);
    checkOutput("rst_lw_data", bus.ma_rdata, 32'h00CCBBAA);

    // rdy low for three cycles in the middle of LW
    repeat (2) @(negedge clk);
    bus.ma_re = 1'b1; bus.ma_addr = 32'h100; bus.ma_width = 3'b010;
    repeat (2) @(negedge clk);
    checkOutput("frz_a_before", bus.mem_a, 32'h101);
    rdy = 1'b0;
    frz = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.mem_a == 32'h101 && bus.ma_busy) frz++;
    end
    checkOutput("frz_hold", frz, 3);
    rdy = 1'b1;
    bc = 5;
    seen_ma = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ma_busy) bc++;
      else begin
        seen_ma = 1;
        break;
      end
    end
    bus.ma_re = 1'b0;
    checkOutput("frz_complete", seen_ma, 1);
    checkOutput("frz_busy", bc, 8);
    checkOutput("frz_data", bus.ma_rdata, 32'h11223344);

`ifndef MEMCTRL_ERR_EN
    // SH across the top of the address space
    repeat (2) @(negedge clk);
    bus.ma_we = 1'b1; bus.ma_addr = 32'hFFFFFFFF; bus.ma_width = 3'b001; bus.ma_wdata = 32'h0000BEEF;
    @(negedge clk);
    checkOutput("wrap_a0", bus.mem_a, 32'hFFFFFFFF);
    checkOutput("wrap_d0", bus.mem_dout, 32'h000000EF);
    @(negedge clk);
    checkOutput("wrap_a1", bus.mem_a, 32'h00000000);
    checkOutput("wrap_d1", bus.mem_dout, 32'h000000BE);
    checkOutput("wrap_wr1", bus.mem_wr, 1);
    @(negedge clk);
    bus.ma_we = 1'b0;
    checkOutput("wrap_busy_end", bus.ma_busy, 0);
    checkOutput("wrap_wr_end", bus.mem_wr, 0);
`else
    // Misaligned LW is rejected without touching the RAM bus
    repeat (2) @(negedge clk);
    bus.ma_re = 1'b1; bus.ma_addr = 32'h102; bus.ma_width = 3'b010;
    @(negedge clk);
    checkOutput("err_busy", bus.ma_busy, 1);
    checkOutput("err_flag", bus.ma_err, 1);
    checkOutput("err_wr", bus.mem_wr, 0);
    checkOutput("err_a", bus.mem_a, 32'h103);
    @(negedge clk);
    bus.ma_re = 1'b0;
    checkOutput("err_busy_end", bus.ma_busy, 0);
    checkOutput("err_rdata", bus.ma_rdata, 32'h11223344);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
